// File: rtl/berger_code_scrubber.sv
// -----------------------------------------------------------------------------
// berger_code_scrubber
//
// Purpose:
//   Sweeps every entry of an external memory once per requested pass. Each
//   entry is a Berger-coded 12-bit word, and the block records which entries
//   fail the check. Entry layout:
//     data  = codeword[11:4]
//     check = codeword[3:0] = number of zero bits in data
//   For a pass the block records:
//     - how many entries failed
//     - a per-entry failure bitmap
//     - the lowest failing address
//     - the direction of the damage
//   On a unidirectional error, the direction shows whether bits flipped
//   0->1 (zero count dropped below check) or 1->0 (zero count rose above
//   check).
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous active-high reset
//   start            request one full pass (accepted only when idle)
//   abort            stop the pass in progress (only while reading/checking)
//   mem_rd_en        memory read strobe
//   mem_addr         memory read address
//   mem_rdata        codeword returned one cycle after mem_rd_en
//   busy             high while a pass is reading/checking
//   done             one-cycle pulse on normal completion of a pass
//   err_count        number of failing entries seen in this pass
//   err_map          bit i set when entry i failed
//   first_err_addr   lowest failing address of the pass
//   first_err_valid  first_err_addr holds a real address
//   z2o_seen         some entry had fewer zeros than its check (0->1 damage)
//   o2z_seen         some entry had more zeros than its check (1->0 damage)
// -----------------------------------------------------------------------------
module berger_code_scrubber #(
    parameter  int ADDR_W = 4,
    localparam int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [11:0]       mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   err_count,
    output logic [DEPTH-1:0]  err_map,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              first_err_valid,
    output logic              z2o_seen,
    output logic              o2z_seen
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   CNT_MAX   = (ADDR_W + 1)'(DEPTH);

    state_t r_state;
    state_t w_state_next;

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_err_count;
    logic [DEPTH-1:0]  r_err_map;
    logic [ADDR_W-1:0] r_first_err_addr;
    logic              r_first_err_valid;
    logic              r_z2o_seen;
    logic              r_o2z_seen;

    // -------------------------------------------------------------------------
    // Berger check of the returned codeword
    // -------------------------------------------------------------------------
    logic [7:0] w_data;
    logic [3:0] w_check;
    logic [3:0] w_zero_term [8];
    logic [3:0] w_zero_count;
    logic       w_mismatch;
    logic       w_fewer_zeros;

    assign w_data  = mem_rdata[11:4];
    assign w_check = mem_rdata[3:0];

    // One term per data bit: 1 when that bit is zero.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_zero_term
            assign w_zero_term[gi] = {3'b000, ~w_data[gi]};
        end
    endgenerate

    always_comb begin
        w_zero_count = '0;
        for (int i = 0; i < 8; i++) begin
            w_zero_count = w_zero_count + w_zero_term[i];
        end
    end

    // The zero count never exceeds 8. Check values 9..15 therefore always
    // compare as "fewer zeros than check" and land in the 0->1 bucket.
    assign w_mismatch    = (w_zero_count != w_check);
    assign w_fewer_zeros = (w_zero_count <  w_check);

    // -------------------------------------------------------------------------
    // Control qualifiers
    // -------------------------------------------------------------------------
    logic w_start_accept;
    logic w_check_commit;
    logic w_last_addr;

    assign w_start_accept = (r_state == S_IDLE) && start;
    // An abort during CHECK discards that entry's result entirely.
    assign w_check_commit = (r_state == S_CHECK) && !abort;
    assign w_last_addr    = (r_addr == LAST_ADDR);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        mem_rd_en    = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_READ;
                end
            end
            S_READ: begin
                mem_rd_en = 1'b1;
                busy      = 1'b1;
                if (abort) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                busy = 1'b1;
                if (abort) begin
                    w_state_next = S_IDLE;
                end else if (w_last_addr) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_READ;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Address counter and result registers
    // Results only change on an accepted start (clear) or a committed CHECK.
    // They therefore hold across DONE, abort and idle time.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr            <= '0;
            r_err_count       <= '0;
            r_err_map         <= '0;
            r_first_err_addr  <= '0;
            r_first_err_valid <= 1'b0;
            r_z2o_seen        <= 1'b0;
            r_o2z_seen        <= 1'b0;
        end else if (w_start_accept) begin
            r_addr            <= '0;
            r_err_count       <= '0;
            r_err_map         <= '0;
            r_first_err_addr  <= '0;
            r_first_err_valid <= 1'b0;
            r_z2o_seen        <= 1'b0;
            r_o2z_seen        <= 1'b0;
        end else if (w_check_commit) begin
            if (w_mismatch) begin
                r_err_map[r_addr] <= 1'b1;
                // Each entry is counted at most once per pass, so DEPTH is
                // the ceiling; the guard keeps the counter from ever rolling.
                if (r_err_count != CNT_MAX) begin
                    r_err_count <= r_err_count + 1'b1;
                end
                if (!r_first_err_valid) begin
                    r_first_err_addr  <= r_addr;
                    r_first_err_valid <= 1'b1;
                end
                if (w_fewer_zeros) begin
                    r_z2o_seen <= 1'b1;
                end else begin
                    r_o2z_seen <= 1'b1;
                end
            end
            // The last address is held rather than wrapped; DONE follows.
            if (!w_last_addr) begin
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    assign mem_addr        = r_addr;
    assign err_count       = r_err_count;
    assign err_map         = r_err_map;
    assign first_err_addr  = r_first_err_addr;
    assign first_err_valid = r_first_err_valid;
    assign z2o_seen        = r_z2o_seen;
    assign o2z_seen        = r_o2z_seen;

endmodule

// File: tb/tb_berger_code_scrubber.sv
// -----------------------------------------------------------------------------
// tb_berger_code_scrubber
//
// Testbench for berger_code_scrubber. It has four parts:
//   - a behavioural memory with a one-cycle read
//   - a pass-level reference model
//   - a per-cycle compare process
//   - directed scenarios with hand-computed literal expectations
//
// The reference model keeps only a position counter within the pass. From
// that counter it derives:
//   - which entries have been judged so far
//   - whether a read or the done pulse is due
// Expected results are computed directly from the snapshot of memory taken
// at start.
// -----------------------------------------------------------------------------
module tb_berger_code_scrubber;

    localparam int AW = 4;
    localparam int D  = 2**AW;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [11:0]   mem_rdata = 12'h000;
    logic          busy;
    logic          done;
    logic [AW:0]   err_count;
    logic [D-1:0]  err_map;
    logic [AW-1:0] first_err_addr;
    logic          first_err_valid;
    logic          z2o_seen;
    logic          o2z_seen;

    berger_code_scrubber #(.ADDR_W(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .mem_rd_en       (mem_rd_en),
        .mem_addr        (mem_addr),
        .mem_rdata       (mem_rdata),
        .busy            (busy),
        .done            (done),
        .err_count       (err_count),
        .err_map         (err_map),
        .first_err_addr  (first_err_addr),
        .first_err_valid (first_err_valid),
        .z2o_seen        (z2o_seen),
        .o2z_seen        (o2z_seen)
    );

    initial forever #5 clk = ~clk;

    // Behavioural memory: data appears the cycle after the read strobe.
    logic [11:0] tb_mem [D];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= tb_mem[mem_addr];
    end

    int n_tests    = 0;
    int n_fail     = 0;
    int cyc        = 0;
    int t0         = 0;
    int done_count = 0;
    int done_rel   = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model
    // m_k counts cycles since the accepted start:
    //   1..2D  reading/checking
    //   2D+1   done
    // m_n is the number of entries judged when the block went idle.
    // ---------------------------------------------------------------------
    bit          m_active = 1'b0;
    int          m_k      = 0;
    int          m_n      = 0;
    logic [11:0] m_snap [D];

    always @(posedge clk) begin
        if (rst) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_n      <= 0;
        end else if (!m_active) begin
            if (start) begin
                m_active <= 1'b1;
                m_k      <= 1;
                m_n      <= 0;
                for (int i = 0; i < D; i++) m_snap[i] <= tb_mem[i];
            end
        end else if (m_k <= 2*D && abort) begin
            m_active <= 1'b0;
            m_n      <= (m_k - 1) / 2;
        end else if (m_k == 2*D + 1) begin
            m_active <= 1'b0;
            m_n      <= D;
        end else begin
            m_k <= m_k + 1;
        end
    end

    // Judge the first n entries of the snapshot by the Berger rule.
    function automatic void expect_results(input int n,
                                           output logic [AW:0]   cnt,
                                           output logic [D-1:0]  map,
                                           output logic [AW-1:0] fa,
                                           output logic          fv,
                                           output logic          z2o,
                                           output logic          o2z);
        logic [11:0] w;
        int zeros;
        int ck;
        cnt = '0; map = '0; fa = '0; fv = 1'b0; z2o = 1'b0; o2z = 1'b0;
        for (int a = 0; a < n; a++) begin
            w = m_snap[a];
            ck = int'(w[3:0]);
            zeros = 0;
            for (int b = 4; b < 12; b++) if (w[b] == 1'b0) zeros++;
            if (zeros != ck) begin
                cnt = cnt + 1'b1;
                map[a] = 1'b1;
                if (!fv) begin
                    fa = a[AW-1:0];
                    fv = 1'b1;
                end
                if (zeros < ck) z2o = 1'b1;
                else            o2z = 1'b1;
            end
        end
    endfunction

    // ---------------------------------------------------------------------
    // Per-cycle compare, on the falling edge
    // ---------------------------------------------------------------------
    logic          e_busy, e_rd, e_done, e_addr_chk;
    int            e_addr, e_n;
    logic [AW:0]   e_cnt;
    logic [D-1:0]  e_map;
    logic [AW-1:0] e_fa;
    logic          e_fv, e_z2o, e_o2z;

    initial begin : compare
        forever begin
            @(negedge clk);
            e_busy = 1'b0; e_rd = 1'b0; e_done = 1'b0; e_addr_chk = 1'b0;
            e_addr = 0; e_n = 0;
            if (rst) begin
                e_addr_chk = 1'b1;
                e_n        = 0;
            end else if (m_active && m_k <= 2*D) begin
                e_busy     = 1'b1;
                e_rd       = ((m_k % 2) == 1);
                e_addr_chk = 1'b1;
                e_addr     = (m_k - 1) / 2;
                e_n        = (m_k - 1) / 2;
            end else if (m_active) begin
                e_done = 1'b1;
                e_n    = D;
            end else begin
                e_n = m_n;
            end
            expect_results(e_n, e_cnt, e_map, e_fa, e_fv, e_z2o, e_o2z);
            chk("cyc_busy",      32'(busy),            32'(e_busy));
            chk("cyc_rd_en",     32'(mem_rd_en),       32'(e_rd));
            chk("cyc_done",      32'(done),            32'(e_done));
            if (e_addr_chk) chk("cyc_addr", 32'(mem_addr), 32'(e_addr));
            chk("cyc_err_count", 32'(err_count),       32'(e_cnt));
            chk("cyc_err_map",   32'(err_map),         32'(e_map));
            chk("cyc_first_vld", 32'(first_err_valid), 32'(e_fv));
            if (e_fv) chk("cyc_first_addr", 32'(first_err_addr), 32'(e_fa));
            chk("cyc_z2o",       32'(z2o_seen),        32'(e_z2o));
            chk("cyc_o2z",       32'(o2z_seen),        32'(e_o2z));
            if (done) begin
                done_count++;
                done_rel = cyc - t0 + 1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Directed scenarios
    // ---------------------------------------------------------------------
    task automatic fill_clean();
        for (int i = 0; i < D; i++) tb_mem[i] = 12'hA54;
    endtask

    // Leaves the bench in cycle 1 of the new pass (start accepted at the
    // end of cycle 0).
    task automatic do_start();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done();
        int w;
        int dc0;
        dc0 = done_count;
        w = 0;
        while (done_count == dc0 && w < 80) begin
            @(posedge clk);
            w++;
        end
        chk("done_seen", 32'(done_count - dc0), 32'd1);
        @(posedge clk); #2;
    endtask

    task automatic check_results(input string tag, input int cnt, input int map,
                                 input int fa, input int fv, input int z2o, input int o2z);
        $display("[TB] %s: done_cycle=%0d err_count=%0d err_map=%04h first=%0d/%0d z2o=%0d o2z=%0d",
                 tag, done_rel, err_count, err_map, first_err_addr, first_err_valid, z2o_seen, o2z_seen);
        chk({tag, "_err_count"}, 32'(err_count),       32'(cnt));
        chk({tag, "_err_map"},   32'(err_map),         32'(map));
        chk({tag, "_first_vld"}, 32'(first_err_valid), 32'(fv));
        if (fv != 0) chk({tag, "_first_addr"}, 32'(first_err_addr), 32'(fa));
        chk({tag, "_z2o"},       32'(z2o_seen),        32'(z2o));
        chk({tag, "_o2z"},       32'(o2z_seen),        32'(o2z));
    endtask

    initial begin : directed
        int dc0;
        fill_clean();
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        check_results("reset", 0, 0, 0, 0, 0, 0);
        chk("reset_busy",  32'(busy),      32'd0);
        chk("reset_rd_en", 32'(mem_rd_en), 32'd0);
        chk("reset_addr",  32'(mem_addr),  32'd0);

        // Clean pass
        fill_clean();
        do_start(); wait_done();
        chk("clean_latency", 32'(done_rel), 32'd33);
        check_results("clean", 0, 0, 0, 0, 0, 0);

        // Single 0->1 error at entry 3 (A7 has three zeros, check 4)
        fill_clean(); tb_mem[3] = 12'hA74;
        do_start(); wait_done();
        chk("z2o_latency", 32'(done_rel), 32'd33);
        check_results("z2o", 1, 32'h0008, 3, 1, 1, 0);

        // 1->0 error at entry 5 plus invalid check 15 at entry 12
        fill_clean(); tb_mem[5] = 12'hA14; tb_mem[12] = 12'hFFF;
        do_start(); wait_done();
        check_results("o2z_inv", 2, 32'h1020, 5, 1, 1, 1);

        // Abort in READ of address 6 (cycle 13), entry 3 corrupt
        fill_clean(); tb_mem[3] = 12'hA74;
        do_start();
        repeat (12) @(posedge clk);
        #2 abort = 1'b1;
        @(posedge clk); #2 abort = 1'b0;
        chk("abort_busy",  32'(busy),      32'd0);
        chk("abort_rd_en", 32'(mem_rd_en), 32'd0);
        dc0 = done_count;
        repeat (40) @(posedge clk);
        #2;
        chk("abort_no_done", 32'(done_count - dc0), 32'd0);
        check_results("abort_read", 1, 32'h0008, 3, 1, 1, 0);

        // Abort in CHECK of address 3 (cycle 8): that entry is not recorded
        do_start();
        repeat (7) @(posedge clk);
        #2 abort = 1'b1;
        @(posedge clk); #2 abort = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check_results("abort_check", 0, 0, 0, 0, 0, 0);

        // Start pulsed in cycle 10 of a pass is ignored
        do_start();
        repeat (9) @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        wait_done();
        chk("busy_start_latency", 32'(done_rel), 32'd33);
        check_results("busy_start", 1, 32'h0008, 3, 1, 1, 0);

        // Reset asserted in cycle 15 of a pass
        do_start();
        repeat (14) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_busy",  32'(busy),      32'd0);
        chk("rst_mid_rd_en", 32'(mem_rd_en), 32'd0);
        chk("rst_mid_addr",  32'(mem_addr),  32'd0);
        chk("rst_mid_done",  32'(done),      32'd0);
        check_results("rst_mid", 0, 0, 0, 0, 0, 0);
        @(posedge clk); #2 rst = 1'b0;
        dc0 = done_count;
        repeat (40) @(posedge clk);
        #2;
        chk("rst_no_done", 32'(done_count - dc0), 32'd0);
        fill_clean();
        do_start(); wait_done();
        chk("after_rst_latency", 32'(done_rel), 32'd33);
        check_results("after_rst", 0, 0, 0, 0, 0, 0);

        // Every entry failing (data 00 has eight zeros, check 0); abort
        // raised during DONE must not suppress the pulse.
        for (int i = 0; i < D; i++) tb_mem[i] = 12'h000;
        do_start();
        repeat (32) @(posedge clk);
        #2 abort = 1'b1;
        @(posedge clk); #2 abort = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("all_bad_latency", 32'(done_rel), 32'd33);
        check_results("all_bad", 16, 32'hFFFF, 0, 1, 0, 1);

        // Only the last address fails (four zeros vs check 0)
        fill_clean(); tb_mem[15] = 12'hA50;
        do_start(); wait_done();
        check_results("last_addr", 1, 32'h8000, 15, 1, 0, 1);

        // Abort while idle changes nothing
        #0 abort = 1'b1;
        repeat (3) @(posedge clk);
        #2 abort = 1'b0;
        check_results("idle_abort", 1, 32'h8000, 15, 1, 0, 1);

        @(negedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/berger_code_scrubber.md
BERGER_CODE_SCRUBBER -- requirements
Module: berger_code_scrubber

Interface
REQ-001 Parameter ADDR_W, default 4, memory address width; the block SHALL sweep DEPTH = 2**ADDR_W entries.
REQ-002 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request one full scrub pass; sampled only in IDLE.
REQ-005 abort  input  1  terminate the pass in progress; sampled only in READ/CHECK.
REQ-006 mem_rd_en  output  1  memory read strobe.
REQ-007 mem_addr  output  ADDR_W  memory read address.
REQ-008 mem_rdata  input  12  codeword from memory, valid exactly one cycle after mem_rd_en.
REQ-009 busy  output  1  high in READ and CHECK.
REQ-010 done  output  1  one-cycle pulse on normal pass completion.
REQ-011 err_count  output  ADDR_W+1  number of failing entries in the current/last pass.
REQ-012 err_map  output  DEPTH  bit i set when entry i failed.
REQ-013 first_err_addr / first_err_valid  output  ADDR_W / 1  lowest failing address in the pass, and its valid flag.
REQ-014 z2o_seen / o2z_seen  output  1 / 1  sticky direction flags for the pass.

Function
REQ-015 Codeword layout SHALL be: data = codeword[11:4], check = codeword[3:0], where a correct check equals the number of zero bits in data (0..8).
REQ-016 The FSM SHALL have states IDLE, READ, CHECK and DONE.
REQ-017 In IDLE with start=1, the block SHALL clear err_count, err_map, first_err_valid, first_err_addr, z2o_seen and o2z_seen, set the address to 0, and enter READ.
REQ-018 In READ, mem_rd_en SHALL be 1 and mem_addr SHALL equal the current address; the next state SHALL be CHECK. In all other states mem_rd_en SHALL be 0.
REQ-019 In CHECK, the block SHALL compute Z = popcount(~data) from mem_rdata and compare it with check.
REQ-020 On mismatch in CHECK, the block SHALL:
- set err_map[addr];
- increment err_count;
- if first_err_valid=0, load first_err_addr=addr and set first_err_valid;
- set z2o_seen if Z < check, else set o2z_seen.
REQ-021 Check values 9..15 SHALL be treated as a mismatch under the same rule, so they set z2o_seen.
REQ-022 On leaving CHECK:
- if addr = DEPTH-1, the next state SHALL be DONE;
- otherwise addr SHALL increment by 1 and the next state SHALL be READ.
REQ-023 The address counter SHALL NOT wrap within a pass.
REQ-024 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-025 Latency: with start accepted in cycle 0, done SHALL be high in cycle 2*DEPTH+1 (cycle 33 for ADDR_W=4).
REQ-026 abort=1 in READ or CHECK SHALL force IDLE on the next edge, with no done pulse and no update from that CHECK cycle.
REQ-027 After an abort, all result outputs SHALL hold their partial values.
REQ-028 start SHALL be ignored outside IDLE.
REQ-029 abort SHALL have no effect in IDLE or DONE.
REQ-030 All result outputs SHALL be held stable from DONE/abort until the next accepted start.
REQ-031 err_count SHALL saturate at DEPTH, which is its natural maximum, so overflow cannot occur.

Reset
REQ-032 On rst=1, regardless of the clock, the state SHALL become IDLE and the address 0.
REQ-033 On rst=1, mem_rd_en, mem_addr, busy, done, err_count, err_map, first_err_addr, first_err_valid, z2o_seen and o2z_seen SHALL all be 0.
REQ-034 Reset asserted mid-pass SHALL discard the pass; no done pulse SHALL follow reset release.

Verification
REQ-035 Clean pass: all 16 entries = 12'hA54 (data A5, four zeros), start -> done in cycle 33, err_count=0, err_map=0, first_err_valid=0, both direction flags 0.
REQ-036 0->1 error: entry 3 = 12'hA74 (data A7, Z=3 < 4), others clean -> err_count=1, err_map=16'h0008, first_err_addr=3, z2o_seen=1, o2z_seen=0.
REQ-037 1->0 and invalid check: entry 5 = 12'hA14 (Z=5 > 4) and entry 12 = 12'hFFF (check 15) -> err_count=2, err_map=16'h1020, first_err_addr=5, o2z_seen=1, z2o_seen=1.
REQ-038 Abort: abort=1 in the READ cycle of address 6, with entry 3 corrupt -> IDLE next cycle, no done, err_count=1, err_map=16'h0008, mem_rd_en=0 thereafter.
REQ-039 Start while busy: start pulsed in cycle 10 of a pass -> no restart, done still in cycle 33, results unchanged.
REQ-040 Reset mid-pass: rst asserted in cycle 15 -> all outputs 0 immediately, IDLE, no done; a new start then completes a normal 33-cycle pass.
